// File: rtl/mic_stat_display.sv
// mic_stat_display
//
// Multi-channel microphone statistics and display capture. Every data_rdy
// strobe updates, for each channel, the latest sample, the peak magnitude
// inside the current display window and a block average over 2^AVG_LOG2
// samples. A free-running refresh counter produces a tick once every
// REFRESH_CYCLES cycles. On that tick one statistic, chosen by mode/ch_sel,
// is captured into disp_val and disp_update pulses for one cycle.

module mic_stat_display #(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 18,
  parameter int DISP_W         = 32,
  parameter int AVG_LOG2       = 4,
  parameter int REFRESH_CYCLES = 1_000_000,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_CH*DATA_W-1:0]   data,
  input  logic                       data_rdy,
  input  logic [1:0]                 mode,
  input  logic [CH_W-1:0]            ch_sel,
  output logic [DISP_W-1:0]          disp_val,
  output logic                       disp_update
);

  // Accumulator holds a full block without overflow.
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [CNT_W-1:0]    TICK_CNT = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [AVG_LOG2-1:0] BLK_LAST = '1;

  localparam logic [1:0] MODE_LATEST = 2'd0;
  localparam logic [1:0] MODE_PEAK   = 2'd1;
  localparam logic [1:0] MODE_AVG    = 2'd2;

  // Refresh timing
  logic [CNT_W-1:0] r_refresh_cnt;
  logic             w_tick;

  // Per-channel derived values for the current input
  logic signed [DATA_W-1:0] w_sample   [NUM_CH];
  logic        [DATA_W-1:0] w_abs      [NUM_CH];
  logic signed [SUM_W-1:0]  w_new_sum  [NUM_CH];
  logic                     w_blk_done [NUM_CH];

  // Per-channel statistics
  logic signed [DATA_W-1:0]   r_latest [NUM_CH];
  logic        [DATA_W-1:0]   r_peak   [NUM_CH];
  logic signed [SUM_W-1:0]    r_sum    [NUM_CH];
  logic        [AVG_LOG2-1:0] r_cnt    [NUM_CH];
  logic signed [DATA_W-1:0]   r_avg    [NUM_CH];

  // Display path
  logic [DISP_W-1:0] w_sel_val;
  logic [DISP_W-1:0] r_disp_val;
  logic              r_disp_update;

  assign w_tick      = (r_refresh_cnt == TICK_CNT);
  assign disp_val    = r_disp_val;
  assign disp_update = r_disp_update;

  // Free-running refresh counter, wraps after the tick cycle.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching real flops.
    if (!reset_n) begin
      r_refresh_cnt <= '0;
    end else if (w_tick) begin
      r_refresh_cnt <= '0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
    end
  end

  // Unpack channel samples and derive magnitude, next sum and block end.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_sample[c] = $signed(data[c*DATA_W +: DATA_W]);
      // The most negative sample maps to 2^(DATA_W-1), which still fits
      // an unsigned DATA_W value, so no saturation is needed.
      w_abs[c]      = w_sample[c][DATA_W-1] ? $unsigned(-w_sample[c])
                                            : $unsigned(w_sample[c]);
      w_new_sum[c]  = r_sum[c] + SUM_W'(w_sample[c]);
      w_blk_done[c] = (r_cnt[c] == BLK_LAST);
    end
  end

  // Per-channel latest / peak / block-average update.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: these per-channel arrays are flops, not RAM, so they can be
      // reset; a reset must discard partial windows and partial blocks.
      for (int c = 0; c < NUM_CH; c++) begin
        r_latest[c] <= '0;
        r_peak[c]   <= '0;
        r_sum[c]    <= '0;
        r_cnt[c]    <= '0;
        r_avg[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (data_rdy) begin
          r_latest[c] <= w_sample[c];
          if (w_blk_done[c]) begin
            // Arithmetic shift floors toward minus infinity.
            r_avg[c] <= DATA_W'(w_new_sum[c] >>> AVG_LOG2);
            r_sum[c] <= '0;
            r_cnt[c] <= '0;
          end else begin
            r_sum[c] <= w_new_sum[c];
            r_cnt[c] <= r_cnt[c] + AVG_LOG2'(1);
          end
        end

        // A tick opens a new peak window; a sample in the tick cycle
        // belongs to the new window.
        if (w_tick) begin
          r_peak[c] <= data_rdy ? w_abs[c] : '0;
        end else if (data_rdy && (w_abs[c] > r_peak[c])) begin
          r_peak[c] <= w_abs[c];
        end
      end
    end
  end

  // Select the displayed statistic from the pre-update register values.
  always_comb begin
    // NOTE: default first so every path assigns w_sel_val and no latch forms.
    w_sel_val = '0;
    if (int'(ch_sel) < NUM_CH) begin
      case (mode)
        MODE_LATEST: w_sel_val = DISP_W'(r_latest[ch_sel]);
        MODE_PEAK:   w_sel_val = DISP_W'(r_peak[ch_sel]);
        MODE_AVG:    w_sel_val = DISP_W'(r_avg[ch_sel]);
        default:     w_sel_val = '0;
      endcase
    end
  end

  // Capture the selection on each tick and pulse disp_update.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_disp_val    <= '0;
      r_disp_update <= 1'b0;
    end else begin
      r_disp_update <= w_tick;
      if (w_tick) begin
        r_disp_val <= w_sel_val;
      end
    end
  end

endmodule

// File: tb/tb_mic_stat_display.sv
// Testbench for mic_stat_display: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.

module tb_mic_stat_display;

  localparam int NUM_CH   = 2;
  localparam int DATA_W   = 18;
  localparam int DISP_W   = 32;
  localparam int AVG_LOG2 = 2;
  localparam int REFRESH  = 16;
  localparam int BLK      = 1 << AVG_LOG2;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NUM_CH*DATA_W-1:0] data = '0;
  logic                     data_rdy = 1'b0;
  logic [1:0]               mode = 2'd0;
  logic [0:0]               ch_sel = 1'b0;
  logic [DISP_W-1:0]        disp_val;
  logic                     disp_update;

  mic_stat_display #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DISP_W(DISP_W),
    .AVG_LOG2(AVG_LOG2), .REFRESH_CYCLES(REFRESH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .data(data), .data_rdy(data_rdy),
    .mode(mode), .ch_sel(ch_sel), .disp_val(disp_val), .disp_update(disp_update)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One strobe cycle: inputs set at a negedge, captured at the next posedge.
  task automatic strobe(input logic [17:0] s0, input logic [17:0] s1);
    data_rdy = 1'b1;
    data     = {s1, s0};
    @(negedge clock);
    data_rdy = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Wait (bounded) until disp_update is seen high; returns negedges waited.
  task automatic wait_update(input string name, output int edges);
    bit found = 1'b0;
    edges = 0;
    for (int k = 1; k <= 3 * REFRESH; k++) begin
      @(negedge clock);
      if (disp_update) begin
        found = 1'b1;
        edges = k;
        break;
      end
    end
    check({name, " update seen"}, {31'b0, found}, 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][17:0] s0;
    logic [3:0][17:0] s1;
    logic [1:0]       mode;
    logic             sel;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input int n,
                              input logic [17:0] a0, a1, a2, a3,
                              input logic [17:0] b0, b1, b2, b3,
                              input logic [1:0] m, input logic s,
                              input logic [31:0] e);
    vec_t v;
    v.n = 3'(n);
    v.s0[0] = a0; v.s0[1] = a1; v.s0[2] = a2; v.s0[3] = a3;
    v.s1[0] = b0; v.s1[1] = b1; v.s1[2] = b2; v.s1[3] = b3;
    v.mode = m; v.sel = s; v.exp = e;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  int m_cyc;
  int m_last[NUM_CH];
  int m_avg[NUM_CH];
  int m_win[NUM_CH][$];
  int m_blk[NUM_CH][$];
  logic [31:0] exp_val;
  logic        exp_upd;

  function automatic int sx(input logic [17:0] v);
    return int'($signed(v));
  endfunction

  function automatic int floor_div(input int num, input int den);
    int q = num / den;
    if ((num % den != 0) && (num < 0)) q -= 1;
    return q;
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    exp_val = '0;
    exp_upd = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_last[c] = 0;
      m_avg[c]  = 0;
      m_win[c].delete();
      m_blk[c].delete();
    end
  endtask

  task automatic model_step();
    int c;
    int pk;
    int s;
    int sum;
    exp_upd = 1'b0;
    if ((m_cyc % REFRESH) == REFRESH - 1) begin
      exp_upd = 1'b1;
      c = int'(ch_sel);
      case (mode)
        2'd0: exp_val = 32'(m_last[c]);
        2'd1: begin
          pk = 0;
          foreach (m_win[c][i]) if (m_win[c][i] > pk) pk = m_win[c][i];
          exp_val = 32'(pk);
        end
        2'd2: exp_val = 32'(m_avg[c]);
        default: exp_val = 32'd0;
      endcase
      for (int k = 0; k < NUM_CH; k++) m_win[k].delete();
    end
    if (data_rdy) begin
      for (int k = 0; k < NUM_CH; k++) begin
        s = sx(data[k*DATA_W +: DATA_W]);
        m_last[k] = s;
        m_win[k].push_back((s < 0) ? -s : s);
        m_blk[k].push_back(s);
        if (m_blk[k].size() == BLK) begin
          sum = 0;
          foreach (m_blk[k][i]) sum += m_blk[k][i];
          m_avg[k] = floor_div(sum, BLK);
          m_blk[k].delete();
        end
      end
    end
    m_cyc++;
  endtask

  function automatic logic [17:0] rand_sample();
    case ($urandom_range(0, 4))
      0: return 18'h20000;
      1: return 18'h1FFFF;
      2: return 18'(int'($urandom_range(0, 40)) - 20);
      default: return 18'($urandom);
    endcase
  endfunction

  // Reset for one edge; checks the reset state while reset is asserted.
  task automatic pulse_reset(input string name);
    reset_n = 1'b0;
    @(negedge clock);
    check({name, " disp_val"}, disp_val, 32'd0);
    check({name, " disp_update"}, {31'b0, disp_update}, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;

    vecs[0] = mk(4, 0, 0, 0, 0, 18'd4, 18'd8, 18'h3FFFC, 18'd12, 2'd2, 1'b1, 32'h00000005);
    vecs[1] = mk(4, 0, 0, 0, 0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFE, 2'd2, 1'b1, 32'hFFFFFFFE);
    vecs[2] = mk(3, 0, 0, 0, 0, 18'd100, 18'd100, 18'd100, 0, 2'd2, 1'b1, 32'hFFFFFFFE);
    vecs[3] = mk(1, 18'h00005, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'h00000005);
    vecs[4] = mk(1, 18'h3FFFF, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'hFFFFFFFF);
    vecs[5] = mk(3, 18'd3, 18'h3FFF9, 18'd5, 0, 0, 0, 0, 0, 2'd1, 1'b0, 32'h00000007);
    vecs[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1'b0, 32'h00000000);
    vecs[7] = mk(1, 18'h20000, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1'b0, 32'h00020000);
    vecs[8] = mk(2, 0, 0, 0, 0, 18'h3FFF0, 18'd3, 0, 0, 2'd1, 1'b1, 32'h00000010);
    vecs[9] = mk(1, 18'd100, 0, 0, 0, 18'h3FF9C, 0, 0, 0, 2'd0, 1'b0, 32'h00000064);

    // Initial reset
    @(negedge clock);
    pulse_reset("initial reset");
    wait_update("first", edges);
    check("first update latency", 32'(edges), 32'd16);

    // Directed table; each vector starts on the cycle after a tick
    foreach (vecs[i]) begin
      mode   = vecs[i].mode;
      ch_sel = vecs[i].sel;
      for (int k = 0; k < int'(vecs[i].n); k++) strobe(vecs[i].s0[k], vecs[i].s1[k]);
      wait_update($sformatf("vec%0d", i), edges);
      check($sformatf("vec%0d disp_val", i), disp_val, vecs[i].exp);
    end

    // ch_sel change mid-window is invisible until the next update
    wait_cycles(5);
    ch_sel = 1'b1;
    wait_cycles(3);
    check("sel hold disp_val", disp_val, 32'h00000064);
    check("sel hold disp_update", {31'b0, disp_update}, 32'd0);
    wait_update("sel switch", edges);
    check("sel switch disp_val", disp_val, 32'hFFFFFF9C);

    // Peak: sample exactly in the tick cycle belongs to the next window
    mode   = 2'd1;
    ch_sel = 1'b0;
    strobe(18'd2, 18'd0);
    wait_cycles(14);
    strobe(18'd9, 18'd0);
    check("tick sample update", {31'b0, disp_update}, 32'd1);
    check("tick sample excluded", disp_val, 32'h00000002);
    wait_update("tick sample next", edges);
    check("tick sample next disp_val", disp_val, 32'h00000009);

    // Reset in the middle of an average block
    mode = 2'd2;
    strobe(18'd7, 18'd0);
    strobe(18'd7, 18'd0);
    pulse_reset("mid reset");
    wait_update("post reset", edges);
    check("post reset latency", 32'(edges), 32'd16);
    check("post reset avg cleared", disp_val, 32'd0);
    for (int k = 0; k < 4; k++) strobe(18'd4, 18'd0);
    wait_update("post reset block", edges);
    check("post reset block avg", disp_val, 32'h00000004);

    // Back-to-back strobes
    for (int k = 1; k <= 4; k++) strobe(18'(k), 18'd0);
    wait_update("back to back", edges);
    check("back to back avg", disp_val, 32'h00000002);

    // Reserved mode and refresh period
    mode = 2'd3;
    wait_update("mode3", edges);
    check("refresh period", 32'(edges), 32'd16);
    check("mode3 disp_val", disp_val, 32'd0);

    // Randomized run against the reference model
    pulse_reset("random reset");
    model_reset();
    for (int cyc = 0; cyc < 320; cyc++) begin
      check("rand disp_update", {31'b0, disp_update}, {31'b0, exp_upd});
      check("rand disp_val", disp_val, exp_val);
      data_rdy = ($urandom_range(0, 99) < 55);
      data     = {rand_sample(), rand_sample()};
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ch_sel = 1'($urandom_range(0, 1));
      @(posedge clock);
      model_step();
      @(negedge clock);
    end
    data_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
